code_entry_controller: RTL and testbench
========================================

// Module: code_entry_controller
// PURPOSE
//  Sequencing FSM of the password-detection design. Takes one-cycle, already-debounced button
//  pulses, collects 4-key codes, compares them with the stored code, and grants or denies access.
//  Counts failures up to a lockout, applies an inactivity timeout, and reprograms the code
//  (only while unlocked). Outputs feed the 7-seg display driver and status LEDs.
// PARAMETERS
//  DEFAULT_CODE   8'hE8  code loaded at reset; digit0 in [1:0] (U=00 D=01 L=10 R=11); E8 = U,L,L,R
//  TIMEOUT_COUNT  200    idle cycles after last accepted key before entry aborts
//  HOLD_COUNT     10     cycles unlock/error stay asserted (OPEN/FAIL dwell)
//  LOCKOUT_COUNT  50     cycles spent in LOCKED
//  MAX_FAILS      3      consecutive mismatches that trigger LOCKED (1..3)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset      in   1  synchronous, active-low reset (sampled on clk rising edge)
//  key_pulse  in   4  one-cycle key strobes: [0]=U [1]=D [2]=L [3]=R
//  prog_sw    in   1  program-mode request (level)
//  state_o    out  3  FSM state: IDLE=0 ENTRY=1 CHECK=2 OPEN=3 FAIL=4 LOCKED=5 PROG=6 COMMIT=7
//  digit_cnt  out  3  keys collected in current entry/program sequence (0..4)
//  fails      out  2  consecutive mismatch count
//  unlock     out  1  high in OPEN
//  error      out  1  high in FAIL
//  locked     out  1  high in LOCKED
//  prog_mode  out  1  high in PROG
//  prog_done  out  1  one-cycle pulse when new code is written
//  timeout    out  1  one-cycle pulse when an entry/program sequence aborts on inactivity
// BEHAVIOUR
//  - reset==0: state IDLE; code_reg=DEFAULT_CODE; buffer, digit_cnt, fails, timers=0; all outputs 0.
//  - Valid key = exactly one bit of key_pulse set. 0 or >=2 bits set: no key, nothing recorded.
//  - IDLE: valid key -> ENTRY, digit stored at buf[1:0], digit_cnt=1. prog_sw ignored.
//  - ENTRY: valid key -> stored at buf[2k+1:2k], digit_cnt+1, timer cleared.
//    4th key -> CHECK on next edge.
//  - Inactivity timer: counts cycles since last accepted key in ENTRY/PROG.
//    At TIMEOUT_COUNT-1 with no key -> IDLE, timeout pulse, digit_cnt=0, fails unchanged.
//    Key and expiry in the same cycle: key wins and the timer restarts.
//  - CHECK (1 cycle): buf==code_reg -> OPEN, fails=0; else -> FAIL, fails+1 (saturating).
//    unlock/error rise 2 cycles after the 4th key pulse.
//  - OPEN: unlock=1 for HOLD_COUNT cycles, then IDLE, digit_cnt=0. Keys ignored.
//    prog_sw==1 during OPEN -> PROG immediately, digit_cnt=0.
//  - FAIL: error=1 for HOLD_COUNT cycles, keys ignored; then LOCKED if fails==MAX_FAILS, else IDLE.
//  - LOCKED: locked=1 for LOCKOUT_COUNT cycles, keys and prog_sw ignored; then IDLE, fails=0.
//  - PROG: collect 4 keys into buf as in ENTRY (same timeout rule; timeout leaves code_reg unchanged).
//    prog_sw falls before the 4th key -> IDLE, code_reg unchanged. 4th key -> COMMIT.
//  - COMMIT (1 cycle): code_reg<=buf, prog_done=1, -> IDLE.
//    prog_sw still high afterwards has no effect until the next OPEN.
//  - Dwell counters and timer are $clog2(max+1) bits wide and cleared on every state entry.
//    Counter widths never wrap before the terminal count.
//  - reset mid-operation in any state: full reset, including code_reg=DEFAULT_CODE.
//  - Outputs are registered: a state change is visible on the same edge it occurs.
// TESTING (TIMEOUT_COUNT=200, HOLD_COUNT=10, LOCKOUT_COUNT=50, MAX_FAILS=3, keys 12 cycles apart)
//  1. Reset, keys U,L,L,R -> state CHECK 1 cycle after R; unlock=1 next cycle for 10 cycles, fails=0.
//  2. U,R,L,R three times -> error 10 cycles each, fails 1,2,3; then locked=1 for 50 cycles.
//     Keys during lock ignored; afterwards fails=0 and U,L,L,R unlocks.
//  3. Unlock, raise prog_sw, keys D,R,R,L -> prog_done pulse, code_reg=8'hBD, then IDLE.
//     U,L,L,R now gives FAIL; D,R,R,L gives OPEN.
//  4. Keys U,L then idle -> timeout pulse exactly 200 cycles after L; digit_cnt=0, fails unchanged.
//     Key on the expiry cycle -> no timeout, digit_cnt=3.
//  5. key_pulse=4'b0101 in ENTRY -> digit_cnt unchanged. prog_sw=1 in IDLE -> no PROG.
//     prog_sw dropped after 2 PROG keys -> IDLE, code unchanged.
//  6. reset low for one edge during PROG after code was 8'hBD -> IDLE, code_reg=8'hE8.
//     All outputs 0 on the following cycle.

Source files
------------

// File: rtl/code_entry_controller.sv
// Code entry sequencer: collects 4-key codes, checks them against a stored
// code, handles OPEN/FAIL dwell, lockout, inactivity timeout and reprogramming.
//
// Ports:
//   clk        system clock (rising edge)
//   reset      synchronous active-low reset
//   key_pulse  one-cycle key strobes [0]=U [1]=D [2]=L [3]=R
//   prog_sw    program-mode request level
//   state_o    FSM state (IDLE..COMMIT = 0..7)
//   digit_cnt  keys collected in the current sequence
//   fails      consecutive mismatch count
//   unlock/error/locked/prog_mode  high in OPEN/FAIL/LOCKED/PROG
//   prog_done  pulse while the new code is committed
//   timeout    pulse when a sequence aborts on inactivity
module code_entry_controller #(
  parameter logic [7:0] DEFAULT_CODE  = 8'hE8,
  parameter int         TIMEOUT_COUNT = 200,
  parameter int         HOLD_COUNT    = 10,
  parameter int         LOCKOUT_COUNT = 50,
  parameter int         MAX_FAILS     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_pulse,
  input  logic       prog_sw,
  output logic [2:0] state_o,
  output logic [2:0] digit_cnt,
  output logic [1:0] fails,
  output logic       unlock,
  output logic       error,
  output logic       locked,
  output logic       prog_mode,
  output logic       prog_done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_CHECK  = 3'd2,
    S_OPEN   = 3'd3,
    S_FAIL   = 3'd4,
    S_LOCKED = 3'd5,
    S_PROG   = 3'd6,
    S_COMMIT = 3'd7
  } state_t;

  // One shared counter serves as inactivity timer and dwell counter;
  // it is sized for the largest terminal count so it never wraps early.
  localparam int M1 =
    (TIMEOUT_COUNT > HOLD_COUNT) ? TIMEOUT_COUNT : HOLD_COUNT;
  localparam int CMAX =
    (M1 > LOCKOUT_COUNT) ? M1 : LOCKOUT_COUNT;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_COUNT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_COUNT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_COUNT - 1);
  localparam logic [1:0]    FAIL_MAX  = 2'(MAX_FAILS);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [7:0]    buf_q, buf_d;
  logic [7:0]    code_q, code_d;
  logic [1:0]    fails_q, fails_d;
  logic          to_d;

  logic          unlock_q, error_q, locked_q;
  logic          prog_mode_q, prog_done_q, timeout_q;

  logic          key_vld;
  logic [1:0]    key_dig;

  function automatic logic [7:0] put_digit(
    input logic [7:0] b,
    input logic [1:0] idx,
    input logic [1:0] d
  );
    logic [7:0] r;
    r = b;
    r[{idx, 1'b0} +: 2] = d;
    return r;
  endfunction

  // Only a single strobe counts as a key; chords and silence are ignored.
  always_comb begin
    key_vld = 1'b0;
    key_dig = 2'd0;
    case (key_pulse)
      4'b0001: begin key_vld = 1'b1; key_dig = 2'd0; end
      4'b0010: begin key_vld = 1'b1; key_dig = 2'd1; end
      4'b0100: begin key_vld = 1'b1; key_dig = 2'd2; end
      4'b1000: begin key_vld = 1'b1; key_dig = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    buf_d   = buf_q;
    code_d  = code_q;
    fails_d = fails_q;
    to_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_vld) begin
          state_d = S_ENTRY;
          buf_d   = {6'd0, key_dig};
          cnt_d   = 3'd1;
        end
      end

      S_ENTRY, S_PROG: begin
        if (state_q == S_PROG && !prog_sw) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (key_vld) begin
          // A key on the expiry cycle wins and restarts the timer.
          buf_d = put_digit(buf_q, cnt_q[1:0], key_dig);
          cnt_d = cnt_q + 3'd1;
          tmr_d = '0;
          if (cnt_q == 3'd3) begin
            state_d = (state_q == S_ENTRY) ? S_CHECK : S_COMMIT;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          to_d    = 1'b1;
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end

      S_CHECK: begin
        if (buf_q == code_q) begin
          state_d = S_OPEN;
          fails_d = 2'd0;
        end else begin
          state_d = S_FAIL;
          if (fails_q != 2'd3) begin
            fails_d = fails_q + 2'd1;
          end
        end
      end

      S_OPEN: begin
        if (prog_sw) begin
          state_d = S_PROG;
          cnt_d   = 3'd0;
          buf_d   = 8'd0;
        end else if (tmr_q == HOLD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end

      S_FAIL: begin
        if (tmr_q == HOLD_LAST) begin
          cnt_d   = 3'd0;
          state_d = (fails_q == FAIL_MAX) ? S_LOCKED : S_IDLE;
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end

      S_LOCKED: begin
        if (tmr_q == LOCK_LAST) begin
          state_d = S_IDLE;
          fails_d = 2'd0;
        end else begin
          tmr_d = tmr_q + CW'(1);
        end
      end

      S_COMMIT: begin
        code_d  = buf_q;
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // Every state entry starts with a fresh timer/dwell count.
    if (state_d != state_q) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      tmr_q       <= '0;
      buf_q       <= 8'd0;
      code_q      <= DEFAULT_CODE;
      fails_q     <= 2'd0;
      unlock_q    <= 1'b0;
      error_q     <= 1'b0;
      locked_q    <= 1'b0;
      prog_mode_q <= 1'b0;
      prog_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      buf_q       <= buf_d;
      code_q      <= code_d;
      fails_q     <= fails_d;
      unlock_q    <= (state_d == S_OPEN);
      error_q     <= (state_d == S_FAIL);
      locked_q    <= (state_d == S_LOCKED);
      prog_mode_q <= (state_d == S_PROG);
      prog_done_q <= (state_d == S_COMMIT);
      timeout_q   <= to_d;
    end
  end

  assign state_o   = state_q;
  assign digit_cnt = cnt_q;
  assign fails     = fails_q;
  assign unlock    = unlock_q;
  assign error     = error_q;
  assign locked    = locked_q;
  assign prog_mode = prog_mode_q;
  assign prog_done = prog_done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_code_entry_controller.sv
// Bench for code_entry_controller: vector table, directed sequences
// and random traffic compared every cycle with a queue-based model.
module tb_code_entry_controller;

  localparam int TO   = 200;
  localparam int HOLD = 10;
  localparam int LOCK = 50;
  localparam int MAXF = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_pulse;
  logic       prog_sw;
  logic [2:0] state_o;
  logic [2:0] digit_cnt;
  logic [1:0] fails;
  logic       unlock, error, locked;
  logic       prog_mode, prog_done, timeout;

  always #5 clk = ~clk;

  code_entry_controller dut (
    .clk       (clk),
    .reset     (reset),
    .key_pulse (key_pulse),
    .prog_sw   (prog_sw),
    .state_o   (state_o),
    .digit_cnt (digit_cnt),
    .fails     (fails),
    .unlock    (unlock),
    .error     (error),
    .locked    (locked),
    .prog_mode (prog_mode),
    .prog_done (prog_done),
    .timeout   (timeout)
  );

  int checks = 0;
  int failures = 0;

  // reference model: state number, stored code, digits as a queue
  int         m_st = 0;
  logic [7:0] m_code = 8'hE8;
  int         m_q[$];
  int         m_fails = 0;
  int         m_t = 0;
  bit         m_to = 1'b0;

  bit psw = 1'b0;
  int n_unlock, n_err, n_lock, n_pdone, n_to;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] q2code();
    logic [7:0] v = '0;
    foreach (m_q[i]) v = v | 8'(m_q[i] << (2 * i));
    return v;
  endfunction

  task automatic go(input int s);
    m_st = s;
    m_t = 0;
  endtask

  task automatic model_edge();
    int nk, dg;
    nk = 0;
    dg = 0;
    for (int i = 0; i < 4; i++)
      if (key_pulse[i]) begin nk++; dg = i; end
    m_to = 1'b0;
    if (!reset) begin
      m_st = 0; m_code = 8'hE8; m_q.delete();
      m_fails = 0; m_t = 0;
      return;
    end
    case (m_st)
      0: if (nk == 1) begin
        m_q.delete(); m_q.push_back(dg); go(1);
      end
      1, 6: begin
        if (m_st == 6 && !prog_sw) begin
          m_q.delete(); go(0);
        end else if (nk == 1) begin
          m_q.push_back(dg); m_t = 0;
          if (m_q.size() == 4) go(m_st == 1 ? 2 : 7);
        end else if (m_t == TO - 1) begin
          m_q.delete(); m_to = 1'b1; go(0);
        end else m_t++;
      end
      2: begin
        if (q2code() == m_code) begin
          m_fails = 0; go(3);
        end else begin
          if (m_fails < 3) m_fails++;
          go(4);
        end
      end
      3: begin
        if (prog_sw) begin m_q.delete(); go(6); end
        else if (m_t == HOLD - 1) begin m_q.delete(); go(0); end
        else m_t++;
      end
      4: begin
        if (m_t == HOLD - 1) begin
          m_q.delete(); go(m_fails == MAXF ? 5 : 0);
        end else m_t++;
      end
      5: begin
        if (m_t == LOCK - 1) begin m_fails = 0; go(0); end
        else m_t++;
      end
      7: begin m_code = q2code(); m_q.delete(); go(0); end
      default: go(0);
    endcase
  endtask

  function automatic logic [13:0] exp_vec();
    return {3'(m_st), 3'(m_q.size()), 2'(m_fails),
            m_st == 3, m_st == 4, m_st == 5,
            m_st == 6, m_st == 7, m_to};
  endfunction

  function automatic logic [13:0] act_vec();
    return {state_o, digit_cnt, fails, unlock, error,
            locked, prog_mode, prog_done, timeout};
  endfunction

  task automatic step(input logic r, input logic [3:0] k);
    logic [13:0] e, a;
    reset = r;
    key_pulse = k;
    prog_sw = psw;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_vec();
    a = act_vec();
    checks++;
    if (a !== e) begin
      failures++;
      if (failures <= 40)
        $display("FAIL cycle_model t=%0t: got %h expected %h", $time, a, e);
    end
    n_unlock += int'(unlock);
    n_err    += int'(error);
    n_lock   += int'(locked);
    n_pdone  += int'(prog_done);
    n_to     += int'(timeout);
    reset = 1'b1;
    key_pulse = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 4'd0);
  endtask

  task automatic send_code(input logic [7:0] c, input int gap);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(1 << c[2 * i +: 2]));
      idle(gap - 1);
    end
  endtask

  typedef struct {
    logic       r;
    logic [3:0] k;
    logic       ps;
    logic [2:0] st;
    logic [2:0] cnt;
    logic [1:0] fl;
    logic [5:0] flags;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset = 1'b0;
    key_pulse = 4'd0;
    prog_sw = 1'b0;
    n_unlock = 0; n_err = 0; n_lock = 0; n_pdone = 0; n_to = 0;

    tbl[0] = '{1'b0, 4'b0000, 1'b0, 3'd0, 3'd0, 2'd0, 6'b000000};
    tbl[1] = '{1'b1, 4'b0001, 1'b0, 3'd1, 3'd1, 2'd0, 6'b000000};
    tbl[2] = '{1'b1, 4'b0101, 1'b0, 3'd1, 3'd1, 2'd0, 6'b000000};
    tbl[3] = '{1'b1, 4'b0100, 1'b0, 3'd1, 3'd2, 2'd0, 6'b000000};
    tbl[4] = '{1'b1, 4'b1111, 1'b0, 3'd1, 3'd2, 2'd0, 6'b000000};
    tbl[5] = '{1'b1, 4'b0100, 1'b0, 3'd1, 3'd3, 2'd0, 6'b000000};
    tbl[6] = '{1'b1, 4'b1000, 1'b0, 3'd2, 3'd4, 2'd0, 6'b000000};
    tbl[7] = '{1'b1, 4'b0000, 1'b0, 3'd3, 3'd4, 2'd0, 6'b100000};
    tbl[8] = '{1'b1, 4'b0001, 1'b0, 3'd3, 3'd4, 2'd0, 6'b100000};

    // table: reset, entry with invalid chords, check, open
    for (int i = 0; i < 9; i++) begin
      psw = tbl[i].ps;
      step(tbl[i].r, tbl[i].k);
      chk($sformatf("tbl%0d_state", i), state_o, tbl[i].st);
      chk($sformatf("tbl%0d_cnt", i), digit_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_fails", i), fails, tbl[i].fl);
      chk($sformatf("tbl%0d_flags", i),
          {unlock, error, locked, prog_mode, prog_done, timeout},
          tbl[i].flags);
    end
    idle(20);
    chk("t1_unlock_cycles", n_unlock, 10);
    chk("t1_idle", state_o, 0);

    // wrong code three times, then lockout
    for (int f = 1; f <= 3; f++) begin
      n_err = 0;
      if (f == 3) n_lock = 0;
      send_code(8'hEC, 12);
      idle(5);
      chk($sformatf("t2_err_cycles_%0d", f), n_err, 10);
      chk($sformatf("t2_fails_%0d", f), fails, f);
    end
    chk("t2_locked", locked, 1);
    for (int i = 0; i < 60; i++)
      step(1'b1, (i < 40 && i % 7 == 0) ? 4'b0001 : 4'b0000);
    chk("t2_lock_cycles", n_lock, 50);
    chk("t2_fails_clr", fails, 0);
    chk("t2_state_idle", state_o, 0);
    chk("t2_cnt_idle", digit_cnt, 0);
    n_unlock = 0;
    send_code(8'hE8, 12);
    idle(5);
    chk("t2_unlock_after", n_unlock, 10);

    // reprogram to D,R,R,L
    n_pdone = 0;
    send_code(8'hE8, 3);
    psw = 1'b1;
    step(1'b1, 4'd0);
    chk("t3_prog_state", state_o, 6);
    chk("t3_prog_mode", prog_mode, 1);
    send_code(8'hBD, 12);
    chk("t3_pdone_pulses", n_pdone, 1);
    chk("t3_idle", state_o, 0);
    psw = 1'b0;
    idle(2);
    n_err = 0;
    send_code(8'hE8, 12);
    idle(5);
    chk("t3_old_code_err", n_err, 10);
    n_unlock = 0;
    send_code(8'hBD, 12);
    idle(5);
    chk("t3_new_code_open", n_unlock, 10);

    // inactivity timeout
    send_code(8'hE8, 12);
    idle(5);
    chk("t4_fails_pre", fails, 1);
    step(1'b1, 4'b0001);
    idle(11);
    step(1'b1, 4'b0100);
    n_to = 0;
    idle(199);
    chk("t4_no_to_early", n_to, 0);
    chk("t4_still_entry", state_o, 1);
    step(1'b1, 4'd0);
    chk("t4_to_pulse", timeout, 1);
    chk("t4_to_state", state_o, 0);
    chk("t4_to_cnt", digit_cnt, 0);
    chk("t4_to_fails", fails, 1);
    step(1'b1, 4'd0);
    chk("t4_to_one_cycle", timeout, 0);
    step(1'b1, 4'b0001);
    idle(11);
    step(1'b1, 4'b0100);
    n_to = 0;
    idle(199);
    step(1'b1, 4'b1000);
    chk("t4_key_wins_cnt", digit_cnt, 3);
    chk("t4_key_wins_to", n_to, 0);
    idle(205);
    chk("t4_second_to", n_to, 1);

    // prog_sw in IDLE, aborted programming
    psw = 1'b1;
    idle(5);
    chk("t5_idle_no_prog", state_o, 0);
    psw = 1'b0;
    idle(1);
    send_code(8'hBD, 3);
    psw = 1'b1;
    step(1'b1, 4'd0);
    chk("t5_prog", state_o, 6);
    step(1'b1, 4'b0001);
    idle(2);
    step(1'b1, 4'b0001);
    idle(2);
    chk("t5_prog_cnt", digit_cnt, 2);
    psw = 1'b0;
    step(1'b1, 4'd0);
    chk("t5_abort_idle", state_o, 0);
    n_unlock = 0;
    send_code(8'hBD, 12);
    idle(5);
    chk("t5_code_kept", n_unlock, 10);

    // reset during PROG restores the default code
    send_code(8'hBD, 3);
    psw = 1'b1;
    step(1'b1, 4'd0);
    step(1'b1, 4'b0010);
    psw = 1'b0;
    step(1'b0, 4'd0);
    chk("t6_all_zero", int'(act_vec()), 0);
    step(1'b1, 4'd0);
    chk("t6_zero_next", int'(act_vec()), 0);
    n_unlock = 0;
    send_code(8'hE8, 12);
    idle(5);
    chk("t6_default_code", n_unlock, 10);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r, idx;
      logic [3:0] k;
      logic rs;
      if ($urandom_range(0, 39) == 0) psw = ~psw;
      rs = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      r = $urandom_range(0, 99);
      k = 4'd0;
      if (r < 10) begin
        idx = m_q.size() % 4;
        if ($urandom_range(0, 1) == 1)
          k = 4'(1 << m_code[2 * idx +: 2]);
        else
          k = 4'(1 << $urandom_range(0, 3));
      end else if (r < 13) begin
        k = 4'($urandom_range(0, 15));
      end
      step(rs, k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
